// File: rtl/gl_triangle_fifo_pkg.sv
// gl_triangle_fifo_pkg
// Shared definitions for the triangle assembly buffer: vertex width, the
// x/y/z field positions inside a packed vertex and the read-side FSM states.
// No ports; imported by gl_triangle_fifo and gl_triangle_fifo_vertex_ram.
package gl_triangle_fifo_pkg;

  // Packed vertex: x = [95:64], y = [63:32], z = [31:0], IEEE-754 single each.
  localparam int VTX_W     = 96;
  localparam int FIELD_W   = 32;
  localparam int X_LSB     = 64;
  localparam int Y_LSB     = 32;
  localparam int Z_LSB     = 0;
  localparam int TRI_VERTS = 3;

  // Read-side dispatch FSM.
  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_DISPATCH = 2'd1,
    ST_BUSY     = 2'd2
  } rd_state_e;

endpackage

// File: rtl/gl_triangle_fifo_vertex_ram.sv
// gl_triangle_fifo_vertex_ram
// DEPTH x 3 x WIDTH register array holding assembled triangles.
// Ports:
//   clk              rising-edge clock
//   wr_en            write one vertex this cycle
//   wr_entry/wr_slot triangle entry and vertex position (0..2) to write
//   wr_data          vertex to write
//   rd_entry         triangle entry to read
//   rd_v0..rd_v2     the three vertices of rd_entry, combinational read
module gl_triangle_fifo_vertex_ram
  import gl_triangle_fifo_pkg::*;
#(
  parameter  int WIDTH = VTX_W,
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [PTR_W-1:0] wr_entry,
  input  logic [1:0]       wr_slot,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [PTR_W-1:0] rd_entry,
  output logic [WIDTH-1:0] rd_v0,
  output logic [WIDTH-1:0] rd_v1,
  output logic [WIDTH-1:0] rd_v2
);

  logic [WIDTH-1:0] v0_q [DEPTH];
  logic [WIDTH-1:0] v1_q [DEPTH];
  logic [WIDTH-1:0] v2_q [DEPTH];
  logic [WIDTH-1:0] v0_d [DEPTH];
  logic [WIDTH-1:0] v1_d [DEPTH];
  logic [WIDTH-1:0] v2_d [DEPTH];

  // Storage is not reset: an entry is only ever read after all three of its
  // slots have been written since the last reset.
  always_comb begin
    v0_d = v0_q;
    v1_d = v1_q;
    v2_d = v2_q;
    if (wr_en) begin
      case (wr_slot)
        2'd0:    v0_d[wr_entry] = wr_data;
        2'd1:    v1_d[wr_entry] = wr_data;
        2'd2:    v2_d[wr_entry] = wr_data;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    v0_q <= v0_d;
    v1_q <= v1_d;
    v2_q <= v2_d;
  end

  assign rd_v0 = v0_q[rd_entry];
  assign rd_v1 = v1_q[rd_entry];
  assign rd_v2 = v2_q[rd_entry];

endmodule

// File: rtl/gl_triangle_fifo.sv
// gl_triangle_fifo
// Triangle assembly buffer in front of the rasterizer. Groups every three
// accepted vertices into a triangle, stores up to DEPTH triangles, and hands
// the oldest one to the rasterizer with a one-cycle dispatch pulse.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   vertex_in/vertex_valid   incoming vertex stream
//   vertex_ready             room for another vertex (transfer = valid && ready)
//   fifo_ready               one-cycle pulse: fifo_in1..3 carry a new triangle
//   fifo_in1..fifo_in3       registered vertices 0/1/2 of the head triangle
//   raster_ready             rasterizer completion; rising edge pops the head
//   tri_count                complete triangles stored, including the one in flight
module gl_triangle_fifo
  import gl_triangle_fifo_pkg::*;
#(
  parameter int VERTEX_TYPE_SIZE = VTX_W,
  parameter int DEPTH            = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [VERTEX_TYPE_SIZE-1:0] vertex_in,
  input  logic                        vertex_valid,
  output logic                        vertex_ready,
  output logic                        fifo_ready,
  output logic [VERTEX_TYPE_SIZE-1:0] fifo_in1,
  output logic [VERTEX_TYPE_SIZE-1:0] fifo_in2,
  output logic [VERTEX_TYPE_SIZE-1:0] fifo_in3,
  input  logic                        raster_ready,
  output logic [$clog2(DEPTH):0]      tri_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  rd_state_e                   state_q, state_d;
  logic [1:0]                  slot_q, slot_d;
  logic [PTR_W-1:0]            wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]            rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]            tri_count_q, tri_count_d;
  logic                        raster_ready_q, raster_ready_d;
  logic [VERTEX_TYPE_SIZE-1:0] fifo_in1_q, fifo_in1_d;
  logic [VERTEX_TYPE_SIZE-1:0] fifo_in2_q, fifo_in2_d;
  logic [VERTEX_TYPE_SIZE-1:0] fifo_in3_q, fifo_in3_d;

  logic                        wr_en;
  logic                        commit;
  logic                        pop;
  logic                        load;
  logic                        raster_rise;
  logic [VERTEX_TYPE_SIZE-1:0] rd_v0, rd_v1, rd_v2;

  gl_triangle_fifo_vertex_ram #(
    .WIDTH (VERTEX_TYPE_SIZE),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk      (clk),
    .wr_en    (wr_en),
    .wr_entry (wr_ptr_q),
    .wr_slot  (slot_q),
    .wr_data  (vertex_in),
    .rd_entry (rd_ptr_q),
    .rd_v0    (rd_v0),
    .rd_v1    (rd_v1),
    .rd_v2    (rd_v2)
  );

  // Only complete triangles count toward fullness, so a partially assembled
  // triangle can always be finished.
  assign vertex_ready = !rst && (tri_count_q < CNT_W'(DEPTH));
  assign wr_en        = vertex_valid && vertex_ready;
  assign commit       = wr_en && (slot_q == 2'd2);

  // Only a fresh rising edge counts; a level already high on entering BUSY
  // belongs to the previous triangle.
  assign raster_rise  = raster_ready && !raster_ready_q;
  assign pop          = (state_q == ST_BUSY) && raster_rise;
  assign load         = (state_q == ST_IDLE) && (tri_count_q != '0);

  // Next-state logic of the dispatch FSM.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:     if (tri_count_q != '0) state_d = ST_DISPATCH;
      ST_DISPATCH: state_d = ST_BUSY;
      ST_BUSY:     if (raster_rise) state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end

  // Output decode of the dispatch FSM.
  always_comb begin
    fifo_ready = (state_q == ST_DISPATCH);
  end

  // Pointers, counters and the head-triangle output registers.
  always_comb begin
    slot_d         = slot_q;
    wr_ptr_d       = wr_ptr_q;
    rd_ptr_d       = rd_ptr_q;
    tri_count_d    = tri_count_q;
    raster_ready_d = raster_ready;
    fifo_in1_d     = fifo_in1_q;
    fifo_in2_d     = fifo_in2_q;
    fifo_in3_d     = fifo_in3_q;

    if (wr_en) begin
      slot_d = (slot_q == 2'd2) ? 2'd0 : slot_q + 2'd1;
    end
    if (commit) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end

    // Simultaneous commit and pop cancel out.
    if (commit && !pop) begin
      tri_count_d = tri_count_q + CNT_W'(1);
    end else if (pop && !commit) begin
      tri_count_d = tri_count_q - CNT_W'(1);
    end

    // The rasterizer reads fifo_in1..3 for the whole triangle, so they only
    // change on IDLE -> DISPATCH.
    if (load) begin
      fifo_in1_d = rd_v0;
      fifo_in2_d = rd_v1;
      fifo_in3_d = rd_v2;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      slot_q         <= 2'd0;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      tri_count_q    <= '0;
      raster_ready_q <= 1'b0;
      fifo_in1_q     <= '0;
      fifo_in2_q     <= '0;
      fifo_in3_q     <= '0;
    end else begin
      state_q        <= state_d;
      slot_q         <= slot_d;
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      tri_count_q    <= tri_count_d;
      raster_ready_q <= raster_ready_d;
      fifo_in1_q     <= fifo_in1_d;
      fifo_in2_q     <= fifo_in2_d;
      fifo_in3_q     <= fifo_in3_d;
    end
  end

  assign fifo_in1  = fifo_in1_q;
  assign fifo_in2  = fifo_in2_q;
  assign fifo_in3  = fifo_in3_q;
  assign tri_count = tri_count_q;

endmodule

// File: tb/tb_gl_triangle_fifo.sv
// tb_gl_triangle_fifo
// Directed bench for gl_triangle_fifo: reset state, single-triangle dispatch
// latency, full/stall behaviour with pointer wrap, back-to-back pops, held
// raster_ready, simultaneous commit/pop and mid-operation reset.
module tb_gl_triangle_fifo;

  localparam int VW    = 96;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [VW-1:0] vertex_in = '0;
  logic          vertex_valid = 1'b0;
  logic          raster_ready = 1'b0;
  logic          vertex_ready;
  logic          fifo_ready;
  logic [VW-1:0] fifo_in1, fifo_in2, fifo_in3;
  logic [2:0]    tri_count;

  int checks = 0;
  int passes = 0;

  // First vertex of every triangle seen during a dispatch pulse, in order.
  logic [VW-1:0] disp_log[$];

  gl_triangle_fifo #(
    .VERTEX_TYPE_SIZE (VW),
    .DEPTH            (DEPTH)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .vertex_in    (vertex_in),
    .vertex_valid (vertex_valid),
    .vertex_ready (vertex_ready),
    .fifo_ready   (fifo_ready),
    .fifo_in1     (fifo_in1),
    .fifo_in2     (fifo_in2),
    .fifo_in3     (fifo_in3),
    .raster_ready (raster_ready),
    .tri_count    (tri_count)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (fifo_ready === 1'b1) disp_log.push_back(fifo_in1);
  end

  function automatic logic [VW-1:0] mk(input int i);
    return {32'(i), 32'(i + 100), 32'(i + 200)};
  endfunction

  function automatic logic [VW-1:0] log_at(input int i);
    logic [VW-1:0] v;
    v = 'x;
    if (i < disp_log.size()) v = disp_log[i];
    return v;
  endfunction

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    vertex_valid = 1'b0;
    raster_ready = 1'b0;
    cycles(2);
    rst = 1'b0;
    disp_log.delete();
  endtask

  task automatic push(input logic [VW-1:0] v);
    vertex_in = v;
    vertex_valid = 1'b1;
    cycles(1);
    vertex_valid = 1'b0;
  endtask

  task automatic pop_once();
    raster_ready = 1'b1;
    cycles(2);
    raster_ready = 1'b0;
    cycles(4);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    vertex_in = mk(5);
    vertex_valid = 1'b1;
    raster_ready = 1'b0;
    cycles(2);
    checks++; if (fifo_ready !== 1'b0) $display("[TB] FAIL reset_fifo_ready: got %b want 0", fifo_ready); else passes++;
    checks++; if ({fifo_in1, fifo_in2, fifo_in3} !== '0) $display("[TB] FAIL reset_fifo_in: got %h want 0", {fifo_in1, fifo_in2, fifo_in3}); else passes++;
    checks++; if (tri_count !== 3'd0) $display("[TB] FAIL reset_tri_count: got %0d want 0", tri_count); else passes++;
    checks++; if (vertex_ready !== 1'b0) $display("[TB] FAIL reset_vertex_ready: got %b want 0", vertex_ready); else passes++;
    rst = 1'b0;
    vertex_valid = 1'b0;
    #1;
    checks++; if (vertex_ready !== 1'b1) $display("[TB] FAIL post_reset_vertex_ready: got %b want 1", vertex_ready); else passes++;
    cycles(1);
    checks++; if (tri_count !== 3'd0) $display("[TB] FAIL post_reset_tri_count: got %0d want 0", tri_count); else passes++;
    disp_log.delete();
  endtask

  task automatic test_single_triangle();
    logic [VW-1:0] v0, v1, v2;
    v0 = {32'h00000000, 32'h00000000, 32'h00000000};
    v1 = {32'h41200000, 32'h00000000, 32'h00000000};
    v2 = {32'h00000000, 32'h41200000, 32'h00000000};
    push(v0);
    push(v1);
    push(v2);
    checks++; if (tri_count !== 3'd1) $display("[TB] FAIL single_tri_count: got %0d want 1", tri_count); else passes++;
    checks++; if (fifo_ready !== 1'b0) $display("[TB] FAIL single_no_early_pulse: got %b want 0", fifo_ready); else passes++;
    cycles(1);
    checks++; if (fifo_ready !== 1'b1) $display("[TB] FAIL single_pulse: got %b want 1", fifo_ready); else passes++;
    checks++; if ({fifo_in1, fifo_in2, fifo_in3} !== {v0, v1, v2}) $display("[TB] FAIL single_data: got %h want %h", {fifo_in1, fifo_in2, fifo_in3}, {v0, v1, v2}); else passes++;
    cycles(1);
    checks++; if (fifo_ready !== 1'b0) $display("[TB] FAIL single_pulse_width: got %b want 0", fifo_ready); else passes++;
    cycles(5);
    checks++; if ({fifo_in1, fifo_in2, fifo_in3} !== {v0, v1, v2}) $display("[TB] FAIL single_hold_busy: got %h want %h", {fifo_in1, fifo_in2, fifo_in3}, {v0, v1, v2}); else passes++;
    checks++; if (disp_log.size() !== 1) $display("[TB] FAIL single_pulse_count: got %0d want 1", disp_log.size()); else passes++;
    raster_ready = 1'b1;
    cycles(1);
    checks++; if (tri_count !== 3'd0) $display("[TB] FAIL single_pop: got %0d want 0", tri_count); else passes++;
    raster_ready = 1'b0;
    cycles(3);
    checks++; if ({fifo_in1, fifo_in2, fifo_in3} !== {v0, v1, v2}) $display("[TB] FAIL single_hold_idle: got %h want %h", {fifo_in1, fifo_in2, fifo_in3}, {v0, v1, v2}); else passes++;
    checks++; if (disp_log.size() !== 1) $display("[TB] FAIL single_no_redispatch: got %0d want 1", disp_log.size()); else passes++;
  endtask

  task automatic test_full();
    apply_reset();
    for (int i = 0; i < 12; i++) push(mk(i));
    checks++; if (tri_count !== 3'd4) $display("[TB] FAIL full_tri_count: got %0d want 4", tri_count); else passes++;
    checks++; if (vertex_ready !== 1'b0) $display("[TB] FAIL full_vertex_ready: got %b want 0", vertex_ready); else passes++;
    vertex_in = mk(12);
    vertex_valid = 1'b1;
    cycles(3);
    checks++; if (tri_count !== 3'd4) $display("[TB] FAIL full_stall_count: got %0d want 4", tri_count); else passes++;
    raster_ready = 1'b1;
    cycles(1);
    checks++; if (tri_count !== 3'd3) $display("[TB] FAIL full_pop_count: got %0d want 3", tri_count); else passes++;
    checks++; if (vertex_ready !== 1'b1) $display("[TB] FAIL full_ready_after_pop: got %b want 1", vertex_ready); else passes++;
    cycles(1);
    vertex_valid = 1'b0;
    raster_ready = 1'b0;
    push(mk(13));
    push(mk(14));
    checks++; if (tri_count !== 3'd4) $display("[TB] FAIL full_refill_count: got %0d want 4", tri_count); else passes++;
    cycles(2);
    for (int k = 0; k < 3; k++) pop_once();
    checks++; if (disp_log.size() !== 5) $display("[TB] FAIL wrap_pulse_count: got %0d want 5", disp_log.size()); else passes++;
    for (int k = 0; k < 5; k++) begin
      checks++; if (log_at(k) !== mk(3 * k)) $display("[TB] FAIL wrap_order_%0d: got %h want %h", k, log_at(k), mk(3 * k)); else passes++;
    end
    checks++; if ({fifo_in1, fifo_in2, fifo_in3} !== {mk(12), mk(13), mk(14)}) $display("[TB] FAIL wrap_stalled_vertex: got %h want %h", {fifo_in1, fifo_in2, fifo_in3}, {mk(12), mk(13), mk(14)}); else passes++;
    pop_once();
    checks++; if (tri_count !== 3'd0) $display("[TB] FAIL full_drain: got %0d want 0", tri_count); else passes++;
  endtask

  task automatic test_back_to_back();
    apply_reset();
    for (int i = 20; i < 26; i++) push(mk(i));
    cycles(4);
    raster_ready = 1'b1;
    cycles(1);
    raster_ready = 1'b0;
    cycles(20);
    raster_ready = 1'b1;
    cycles(1);
    raster_ready = 1'b0;
    cycles(3);
    checks++; if (disp_log.size() !== 2) $display("[TB] FAIL b2b_pulse_count: got %0d want 2", disp_log.size()); else passes++;
    checks++; if (log_at(0) !== mk(20)) $display("[TB] FAIL b2b_first: got %h want %h", log_at(0), mk(20)); else passes++;
    checks++; if (log_at(1) !== mk(23)) $display("[TB] FAIL b2b_second: got %h want %h", log_at(1), mk(23)); else passes++;
    checks++; if (tri_count !== 3'd0) $display("[TB] FAIL b2b_count: got %0d want 0", tri_count); else passes++;
  endtask

  task automatic test_hold_high();
    apply_reset();
    for (int i = 30; i < 36; i++) push(mk(i));
    cycles(4);
    raster_ready = 1'b1;
    cycles(10);
    checks++; if (tri_count !== 3'd1) $display("[TB] FAIL hold_single_pop: got %0d want 1", tri_count); else passes++;
    checks++; if (disp_log.size() !== 2) $display("[TB] FAIL hold_pulse_count: got %0d want 2", disp_log.size()); else passes++;
    raster_ready = 1'b0;
    cycles(1);
    raster_ready = 1'b1;
    cycles(1);
    checks++; if (tri_count !== 3'd0) $display("[TB] FAIL hold_second_pop: got %0d want 0", tri_count); else passes++;
    raster_ready = 1'b0;
    cycles(2);
  endtask

  task automatic test_commit_and_pop();
    apply_reset();
    for (int i = 40; i < 46; i++) push(mk(i));
    cycles(4);
    push(mk(46));
    push(mk(47));
    checks++; if (tri_count !== 3'd2) $display("[TB] FAIL cp_pre_count: got %0d want 2", tri_count); else passes++;
    vertex_in = mk(48);
    vertex_valid = 1'b1;
    raster_ready = 1'b1;
    cycles(1);
    vertex_valid = 1'b0;
    raster_ready = 1'b0;
    checks++; if (tri_count !== 3'd2) $display("[TB] FAIL cp_same_cycle: got %0d want 2", tri_count); else passes++;
    cycles(3);
    checks++; if (tri_count !== 3'd2) $display("[TB] FAIL cp_settled: got %0d want 2", tri_count); else passes++;
    checks++; if (log_at(1) !== mk(43)) $display("[TB] FAIL cp_next_dispatch: got %h want %h", log_at(1), mk(43)); else passes++;
  endtask

  task automatic test_reset_mid();
    apply_reset();
    for (int i = 60; i < 63; i++) push(mk(i));
    cycles(4);
    push(mk(63));
    push(mk(64));
    rst = 1'b1;
    cycles(1);
    checks++; if (fifo_ready !== 1'b0) $display("[TB] FAIL mid_rst_fifo_ready: got %b want 0", fifo_ready); else passes++;
    checks++; if ({fifo_in1, fifo_in2, fifo_in3} !== '0) $display("[TB] FAIL mid_rst_fifo_in: got %h want 0", {fifo_in1, fifo_in2, fifo_in3}); else passes++;
    checks++; if (tri_count !== 3'd0) $display("[TB] FAIL mid_rst_count: got %0d want 0", tri_count); else passes++;
    checks++; if (vertex_ready !== 1'b0) $display("[TB] FAIL mid_rst_vertex_ready: got %b want 0", vertex_ready); else passes++;
    rst = 1'b0;
    disp_log.delete();
    push(mk(70));
    push(mk(71));
    push(mk(72));
    cycles(1);
    checks++; if (fifo_ready !== 1'b1) $display("[TB] FAIL mid_rst_pulse: got %b want 1", fifo_ready); else passes++;
    checks++; if ({fifo_in1, fifo_in2, fifo_in3} !== {mk(70), mk(71), mk(72)}) $display("[TB] FAIL mid_rst_new_tri: got %h want %h", {fifo_in1, fifo_in2, fifo_in3}, {mk(70), mk(71), mk(72)}); else passes++;
    cycles(1);
    checks++; if (fifo_ready !== 1'b0) $display("[TB] FAIL mid_rst_pulse_width: got %b want 0", fifo_ready); else passes++;
  endtask

  initial begin
    $display("[TB] starting gl_triangle_fifo bench");
    test_reset();
    test_single_triangle();
    test_full();
    test_back_to_back();
    test_hold_high();
    test_commit_and_pop();
    test_reset_mid();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
